// File: rtl/vna_switch_sequencer.sv
// N-channel RF switch sequencer: active-low one-hot switch drive, settle/trigger/ready stepping for a VNA.
// Optional build macro SWEEP_LIMIT_EN adds sweep_lim[7:0] to stop after a number of full passes.
module vna_switch_sequencer #(
  parameter int N_CH       = 3,
  parameter int SETTLE_CYC = 16,
  parameter int TRIG_DLY   = 5,
  parameter int TRIG_LEN   = 25,
  parameter int SYNC_STG   = 4,
  parameter int CHW        = $clog2(N_CH)
) (
  input  logic            Clk,
  input  logic            nRst,
  input  logic            VNA_RDY,
  // cmd_valid is a one-cycle strobe with no ready: every strobe is evaluated on the edge it is
  // sampled, and an illegal HOLD channel, an empty SWEEP mask or the reserved mode is dropped.
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_mode,
  input  logic [CHW-1:0]  cmd_chan,
  input  logic [N_CH-1:0] cmd_mask,
`ifdef SWEEP_LIMIT_EN
  input  logic [7:0]      sweep_lim,
`endif
  output logic            VNA_TRIG,
  output logic [N_CH-1:0] sw_J,
  output logic [CHW-1:0]  cur_chan,
  output logic            busy,
  output logic            sweep_done,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    TRIG     = 2'd2,
    WAIT_RDY = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_SWEEP = 2'd1;
  localparam logic [1:0] MODE_STOP  = 2'd2;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TRIG_LAST   = 8'(TRIG_DLY + TRIG_LEN - 1);
  localparam logic [8:0] TRIG_ON     = 9'(TRIG_DLY);
  localparam logic       TRIG_AT_0   = (TRIG_DLY == 0);

  state_t            state;
  logic [7:0]        cnt;
  logic [N_CH-1:0]   mask_reg;
  logic [SYNC_STG-1:0] rdy_sync;
  logic              rdy_rise;
  logic              hold_ok;
  logic              sweep_ok;
  logic              stop_ok;
  logic [CHW-1:0]    cmd_low_chan;
  logic [CHW-1:0]    step_chan;
  logic              step_wrap;

`ifdef SWEEP_LIMIT_EN
  logic [7:0]        lim_reg;
  logic [7:0]        pass_cnt;
  logic [CHW-1:0]    mask_low_chan;
`endif

  function automatic logic [CHW-1:0] lowest_chan(input logic [N_CH-1:0] m);
    logic [CHW-1:0] ch;
    ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) ch = CHW'(i);
    end
    return ch;
  endfunction

  // Next enabled channel strictly above cur with wrap-around; the MSB of the result flags a wrap.
  // A single-bit mask finds nothing and returns cur with the wrap flag set.
  function automatic logic [CHW:0] next_chan(input logic [N_CH-1:0] m, input logic [CHW-1:0] cur);
    logic [CHW-1:0] ch;
    logic           wr;
    logic           found;
    int             idx;
    ch    = cur;
    wr    = 1'b1;
    found = 1'b0;
    for (int i = 1; i < N_CH; i++) begin
      idx = int'(cur) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && m[idx]) begin
        found = 1'b1;
        ch    = CHW'(idx);
        wr    = (int'(cur) + i >= N_CH);
      end
    end
    return {wr, ch};
  endfunction

  always_comb begin
    hold_ok      = cmd_valid && (cmd_mode == MODE_HOLD) && (int'(cmd_chan) < N_CH);
    sweep_ok     = cmd_valid && (cmd_mode == MODE_SWEEP) && (cmd_mask != '0);
    stop_ok      = cmd_valid && (cmd_mode == MODE_STOP);
    cmd_low_chan = lowest_chan(cmd_mask);
    {step_wrap, step_chan} = next_chan(mask_reg, cur_chan);
    rdy_rise     = !rdy_sync[SYNC_STG-1] && rdy_sync[SYNC_STG-2];
`ifdef SWEEP_LIMIT_EN
    mask_low_chan = lowest_chan(mask_reg);
`endif
  end

  // VNA_TRIG is loaded one count ahead so that, while in TRIG, it is high exactly when
  // cnt lies in [TRIG_DLY, TRIG_DLY+TRIG_LEN-1].
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_chan   <= '0;
      mask_reg   <= '0;
      rdy_sync   <= '0;
      VNA_TRIG   <= 1'b0;
      sweep_done <= 1'b0;
`ifdef SWEEP_LIMIT_EN
      lim_reg    <= '0;
      pass_cnt   <= '0;
`endif
    end else begin
      rdy_sync   <= {rdy_sync[SYNC_STG-2:0], VNA_RDY};
      sweep_done <= 1'b0;
      if (hold_ok) begin
        cur_chan <= cmd_chan;
        state    <= IDLE;
        cnt      <= '0;
        VNA_TRIG <= 1'b0;
      end else if (stop_ok) begin
        state    <= IDLE;
        cnt      <= '0;
        VNA_TRIG <= 1'b0;
      end else if (sweep_ok) begin
        mask_reg <= cmd_mask;
        cur_chan <= cmd_low_chan;
        state    <= SETTLE;
        cnt      <= '0;
        VNA_TRIG <= 1'b0;
`ifdef SWEEP_LIMIT_EN
        lim_reg  <= sweep_lim;
        pass_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state    <= TRIG;
              cnt      <= '0;
              VNA_TRIG <= TRIG_AT_0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          TRIG: begin
            if (cnt == TRIG_LAST) begin
              state    <= WAIT_RDY;
              cnt      <= '0;
              VNA_TRIG <= 1'b0;
            end else begin
              cnt      <= cnt + 8'd1;
              VNA_TRIG <= ({1'b0, cnt} + 9'd1 >= TRIG_ON);
            end
          end
          WAIT_RDY: begin
            if (rdy_rise) begin
              cur_chan   <= step_chan;
              sweep_done <= step_wrap;
              state      <= SETTLE;
              cnt        <= '0;
`ifdef SWEEP_LIMIT_EN
              if (step_wrap) begin
                pass_cnt <= pass_cnt + 8'd1;
                if ((lim_reg != 8'd0) && (pass_cnt + 8'd1 == lim_reg)) begin
                  state    <= IDLE;
                  cur_chan <= mask_low_chan;
                end
              end
`endif
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sw_J[i] = (cur_chan != CHW'(i));
    end
    busy      = (state != IDLE);
    dbg_state = state;
  end

endmodule
